// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM state encoding plus the width helpers
// used by the Booth multiplier and divider and by their benches.
package arith_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        ZERO = 3'd3,
        DONE = 3'd4
    } state_t;

    // Ceiling log2; used to size iteration counters that run 0..width-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Most negative two's-complement value of the given width, low bits significant.
    function automatic logic [31:0] min_val(input int width);
        return 32'h1 << (width - 1);
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude and keep the difference when it is non-negative.
module booth_div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [2*WIDTH:0] pair;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH:0]   trial;

    // The partial remainder stays below |divisor|, so the bit shifted out of
    // the top is always zero and WIDTH+1 bits hold the signed trial result.
    always_comb begin
        pair     = {rem, quo} << 1;
        rem_sh   = pair[2*WIDTH:WIDTH];
        quo_sh   = pair[WIDTH-1:0];
        trial    = rem_sh - {1'b0, dvs};
        rem_next = trial[WIDTH] ? rem_sh : trial;
        quo_next = quo_sh | {{(WIDTH-1){1'b0}}, ~trial[WIDTH]};
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider (restoring, one quotient bit per clock, truncating).
// Define BOOTH_DIV_OVF_FLAG_EN to add the ovf_o flag for MIN / -1.
module booth_div #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
`ifdef BOOTH_DIV_OVF_FLAG_EN
    ,
    output logic             ovf_o
`endif
);
    import arith_pkg::*;

    localparam int CNT_W = clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dividend_q;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    assign dividend_mag = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
    assign divisor_mag  = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;

    booth_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvs      (dvs_mag),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        done_o     = (state == DONE);
        case (state)
            IDLE: if (start) state_next = (divisor_i == '0) ? ZERO : CALC;
            CALC: if (count == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:  state_next = DONE;
            ZERO: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The quotient register starts as |dividend| and fills with quotient bits
    // from the bottom while the dividend bits move into rem from the top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem           <= '0;
            quo           <= '0;
            dvs_mag       <= '0;
            dividend_q    <= '0;
            dividend_neg  <= 1'b0;
            divisor_neg   <= 1'b0;
            count         <= '0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    dividend_q    <= dividend_i;
                    dividend_neg  <= dividend_i[WIDTH-1];
                    divisor_neg   <= divisor_i[WIDTH-1];
                    dvs_mag       <= divisor_mag;
                    quo           <= dividend_mag;
                    rem           <= '0;
                    count         <= '0;
                    quotient_o    <= '0;
                    remainder_o   <= '0;
                    div_by_zero_o <= 1'b0;
                end
                CALC: begin
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    quotient_o  <= (dividend_neg ^ divisor_neg) ? -quo : quo;
                    remainder_o <= dividend_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end
                ZERO: begin
                    quotient_o    <= '1;
                    remainder_o   <= dividend_q;
                    div_by_zero_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_DIV_OVF_FLAG_EN
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_val(WIDTH));

    logic ovf_pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_pending <= 1'b0;
            ovf_o       <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf_pending <= (dividend_i == MIN_VAL) && (divisor_i == '1);
            ovf_o       <= 1'b0;
        end else if (state == FIX) begin
            ovf_o <= ovf_pending;
        end
    end
`else
    // MIN / -1 wraps to quotient MIN, remainder 0 with no indication.
`endif

endmodule

// File: tb/tb_booth_div.sv
// Scoreboard bench for booth_div (WIDTH=4): directed vectors push expected
// results; a monitor pops and compares on every done_o pulse.
module tb_booth_div;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           done_cyc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef BOOTH_DIV_OVF_FLAG_EN
    logic         ovf;
`endif

    exp_t sb[$];
    int   cyc;
    int   tests;
    int   failed;

    booth_div #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
`ifdef BOOTH_DIV_OVF_FLAG_EN
        ,
        .ovf_o         (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) check_output("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic dbz, input logic ov);
        exp_t e;
        e.q        = q;
        e.r        = r;
        e.dbz      = dbz;
        e.ovf      = ov;
        e.done_cyc = cyc + (dbz ? 2 : W + 2);
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] q, input logic [W-1:0] r,
                                  input logic dbz, input logic ov);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push_exp(q, r, dbz, ov);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("quotient", 32'(quotient), 32'(e.q));
                    check_output("remainder", 32'(remainder), 32'(e.r));
                    check_output("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check_output("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check_output("busy_at_done", 32'(busy), 32'd1);
`ifdef BOOTH_DIV_OVF_FLAG_EN
                    check_output("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        logic [W-1:0] p_dvd [8];
        logic [W-1:0] p_dvs [8];
        tests    = 0;
        failed   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_quotient", 32'(quotient), 32'd0);
        check_output("reset_remainder", 32'(remainder), 32'd0);
        check_output("reset_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b1;

        // Signed vectors, values in 4-bit two's complement.
        apply_stimulus(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 1'b0);     // 7/2 = 3 r 1
        apply_stimulus(4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0);     // -7/2 = -3 r -1
        apply_stimulus(4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 1'b0);     // 7/-2 = -3 r 1
        apply_stimulus(4'h9, 4'hE, 4'd3, 4'hF, 1'b0, 1'b0);     // -7/-2 = 3 r -1
        apply_stimulus(4'd5, 4'd0, 4'hF, 4'd5, 1'b1, 1'b0);     // 5/0
        apply_stimulus(4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 1'b1);     // -8/-1 wraps
        apply_stimulus(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);     // 0/5
        apply_stimulus(4'h8, 4'd7, 4'hF, 4'hF, 1'b0, 1'b0);     // -8/7 = -1 r -1
        apply_stimulus(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 1'b0);     // 3/7 = 0 r 3
        apply_stimulus(4'hD, 4'd0, 4'hF, 4'hD, 1'b1, 1'b0);     // -3/0
        apply_stimulus(4'd1, 4'h8, 4'd0, 4'd1, 1'b0, 1'b0);     // 1/-8 = 0 r 1
        apply_stimulus(4'h8, 4'd3, 4'hE, 4'hE, 1'b0, 1'b0);     // -8/3 = -2 r -2

        wait_idle();
        repeat (3) @(negedge clk);
        check_output("held_quotient", 32'(quotient), 32'hE);
        check_output("held_remainder", 32'(remainder), 32'hE);

        // start held high with new operands each cycle: only k=0 and the first
        // IDLE cycle after DONE (k=7) are accepted.
        p_dvd = '{4'd7, 4'd1, 4'd2, 4'hF, 4'd3, 4'd4, 4'd5, 4'hA};
        p_dvs = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd4};
        wait_idle();
        for (int k = 0; k < 8; k++) begin
            start    = 1'b1;
            dividend = p_dvd[k];
            divisor  = p_dvs[k];
            if (k == 0) push_exp(4'd3, 4'd1, 1'b0, 1'b0);
            if (k == 7) push_exp(4'hF, 4'hE, 1'b0, 1'b0);      // -6/4 = -1 r -2
            @(negedge clk);
        end
        start = 1'b0;

        // Abort in the second CALC cycle; no done_o may follow.
        wait_idle();
        start    = 1'b1;
        dividend = 4'd7;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_quotient", 32'(quotient), 32'd0);
        check_output("abort_remainder", 32'(remainder), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_output("post_abort_busy", 32'(busy), 32'd0);
        apply_stimulus(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b0);     // 6/3 = 2 r 0

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_output("scoreboard_drain", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
Sequential signed integer divider: the inverse operator to the team's Booth multiplier, sharing its start/accumulator-shift style and operand width. It accepts a dividend and divisor on a start pulse and runs a restoring shift-subtract loop, one quotient bit per clock. It returns a truncating (round-toward-zero) quotient and remainder, then pulses done. It sits beside the multiplier in the arithmetic block and feeds the same result bus consumers.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (two's complement), legal range 2..32

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE
dividend_i  input  WIDTH  signed dividend
divisor_i  input  WIDTH  signed divisor
busy_o  output  1  high from cycle after accepted start until done_o cycle inclusive
done_o  output  1  one-cycle pulse; results valid from this cycle
quotient_o  output  WIDTH  signed quotient, held until next accepted start
remainder_o  output  WIDTH  signed remainder, held until next accepted start
div_by_zero_o  output  1  set with done_o when divisor was 0, held with results

Behaviour:
- Reset (rst low, async): state IDLE; busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0; count and internal registers cleared. Reset mid-operation aborts with no done_o.
- Accepted start (start=1 in IDLE) latches both operands, their signs, and the magnitudes |dividend| and |divisor| (WIDTH-bit unsigned; |MIN| = 2^(WIDTH-1) fits). busy_o rises and results and div_by_zero_o clear.
- States: IDLE -> CALC (divisor != 0) or ZERO (divisor == 0); CALC -> FIX after WIDTH iterations; FIX -> DONE; ZERO -> DONE; DONE -> IDLE unconditionally.
- CALC, per cycle:
  - Left-shift {rem, quo} by 1, where rem is a WIDTH+1-bit partial remainder.
  - trial = rem - |divisor|.
  - If trial is non-negative, rem = trial and quo LSB = 1; else quo LSB = 0.
  - count increments 0..WIDTH-1; exit when count == WIDTH-1.
- FIX: quotient negated if sign(dividend) XOR sign(divisor); remainder negated if dividend negative. Results are truncated to WIDTH bits.
- DONE: drive quotient_o/remainder_o, done_o=1 for exactly this cycle, busy_o=1 this cycle, then return to IDLE.
- Latency: start accepted at edge N; done_o high in cycle N+WIDTH+2 (CALC ×WIDTH, FIX, DONE). Divide-by-zero: done_o at N+2.
- Divide by zero: quotient_o = all ones (-1), remainder_o = dividend_i, div_by_zero_o = 1.
- Overflow MIN / -1: the magnitude result 2^(WIDTH-1) wraps, so quotient_o = MIN and remainder_o = 0.
- start asserted while busy is ignored; operands are not re-sampled. start held high through DONE is accepted again in the following IDLE cycle.
- Identity checked by bench: quotient*divisor + remainder == dividend (non-zero divisor, non-overflow); |remainder| < |divisor|.

Optional Feature:
BOOTH_DIV_OVF_FLAG_EN
- Defined: adds output ovf_o (1 bit, reset 0). ovf_o is set with done_o when dividend == MIN and divisor == -1, held with the results, and cleared on the next accepted start. Result values are unchanged (wrapped MIN, 0).
- Undefined: port absent; the wrapped result is returned silently.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding localparams (IDLE, CALC, FIX, ZERO, DONE; 3-bit);
  - counter-width function clog2(WIDTH);
  - the MIN-value constant function used by both multiplier and divider benches.
- One natural sub-module, booth_div_step: combinational single restoring iteration. Inputs are rem, quo and |divisor|; outputs are next rem and next quo. It is instantiated once in CALC and is reusable for an unrolled variant.

Test Plan:
- WIDTH=4: 7 / 2 -> after 6 cycles done_o, quotient 3, remainder 1, div_by_zero_o 0.
- Signs: -7/2 -> q=-3 r=-1; 7/-2 -> q=-3 r=1; -7/-2 -> q=3 r=-1.
- Divide by zero: 5 / 0 -> done_o at cycle 2, quotient 4'hF, remainder 5, div_by_zero_o 1.
- Overflow: -8 / -1 -> quotient -8, remainder 0; with BOOTH_DIV_OVF_FLAG_EN ovf_o=1, otherwise no such port.
- Protocol: start=1 held continuously with new operands every cycle -> only the first accepted while busy; back-to-back ops complete with exactly one done_o each.
- Reset: assert rst low in CALC cycle 2 -> outputs 0 immediately, no done_o. A fresh 6 / 3 after release -> q=2 r=0.
